// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM
// with a sticky illegal-instruction trap and a retire counter.
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        write_reg,
  input  logic        write_mem,
  input  logic        read_ram,
  input  logic        illegal,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        trap,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        ipend_q, ipend_d;
  logic [31:0] instret_q, instret_d;
  logic        mem_op;
  logic        bad_op;

  assign mem_op = write_mem | read_ram;
  assign bad_op = illegal | (write_mem & read_ram);

  always_comb begin
    state_d  = state_q;
    ipend_d  = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    mdr_we   = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    trap     = 1'b0;
    case (state_q)
      S_FETCH: begin
        // a raised fetch stays raised until acked, even if run drops
        imem_req = run | ipend_q;
        ipend_d  = imem_req & ~imem_ack;
        if (imem_req && imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = bad_op ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        if (mem_op) begin
          state_d = S_MEM;
        end else if (write_reg) begin
          state_d = S_WB;
        end else begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = write_mem;
        if (dmem_ack) begin
          if (read_ram) begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (!rst_n) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      mdr_we   = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      trap     = 1'b0;
    end
  end

  assign instret_d = instret_q + {31'd0, pc_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ipend_q   <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      ipend_q   <= ipend_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized instruction stream with memory
// responders, scoreboard of expected retires, and directed corners.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        write_reg = 1'b0;
  logic        write_mem = 1'b0;
  logic        read_ram = 1'b0;
  logic        illegal = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we;
  logic        mdr_we, rf_we, pc_we, trap;
  logic [2:0]  state;
  logic [31:0] instret;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int lat;
    bit rf;
    int ld;
    bit st;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] exp_instret = 32'd0;
  bit          chk_inst = 1'b0;
  bit          in_flight = 1'b0;
  bit          dwe = 1'b0;
  int          cnt = 0;
  int          mdr_n = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .write_reg (write_reg),
    .write_mem (write_mem),
    .read_ram  (read_ram),
    .illegal   (illegal),
    .imem_req  (imem_req),
    .ir_we     (ir_we),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .mdr_we    (mdr_we),
    .rf_we     (rf_we),
    .pc_we     (pc_we),
    .trap      (trap),
    .state     (state),
    .instret   (instret)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: times each instruction from ir_we to its retire pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_instret = 32'd0;
      chk_inst = 1'b0;
      in_flight = 1'b0;
    end else begin
      if (chk_inst) begin
        check("instret", instret, exp_instret);
        chk_inst = 1'b0;
      end
      if (ir_we) begin
        in_flight = 1'b1;
        cnt = 0;
        mdr_n = 0;
        dwe = 1'b0;
      end
      if (in_flight) cnt++;
      if (mdr_we) mdr_n++;
      if (dmem_req && dmem_we) dwe = 1'b1;
      if (rf_we) check("rf_we_without_pc_we", 32'(pc_we), 1);
      if (pc_we) begin
        if (sb.size() == 0) begin
          check("retire_expected", 32'(sb.size()), 1);
        end else begin
          mon_e = sb.pop_front();
          check("latency", 32'(cnt), 32'(mon_e.lat));
          check("rf_we", 32'(rf_we), 32'(mon_e.rf));
          check("mdr_we_count", 32'(mdr_n), 32'(mon_e.ld));
          check("store_dmem_we", 32'(dwe), 32'(mon_e.st));
        end
        exp_instret = exp_instret + 32'd1;
        chk_inst = 1'b1;
        in_flight = 1'b0;
      end
    end
  end

  // kind: 0 branch, 1 alu, 2 load, 3 store, 4 illegal, 5 load+store
  task automatic exec_instr(input int kind, input int iw, input int dw,
                            input int gap, input int abort_at);
    logic wr, wm, rr, il;
    int   cyc;
    int   lat;
    bit   done;
    wr = 1'b0; wm = 1'b0; rr = 1'b0; il = 1'b0;
    cyc = 0;
    done = 1'b0;
    case (kind)
      1: wr = 1'b1;
      2: begin rr = 1'b1; wr = 1'b1; end
      3: begin wm = 1'b1; wr = 1'($urandom); end
      4: begin il = 1'b1; wr = 1'($urandom); end
      5: begin wm = 1'b1; rr = 1'b1; end
      default: ;
    endcase
    if (kind < 4) begin
      lat = 3 + ((wm | rr) ? 1 + dw : 0)
              + ((rr | (wr & ~wm)) ? 1 : 0);
      sb.push_back('{lat, rr | (wr & ~wm), int'(rr), wm});
    end
    run = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("gap_no_imem_req", 32'(imem_req), 0);
      tick();
    end
    run = 1'b1;
    {write_reg, write_mem, read_ram, illegal} = 4'($urandom);
    while (!done) begin
      if (abort_at != 0 && cyc == abort_at) begin
        check("pre_abort_dmem_req", 32'(dmem_req), 1);
        rst_n = 1'b0;
        #1;
        check("abort_dmem_req", 32'(dmem_req), 0);
        check("abort_state", 32'(state), 0);
        check("abort_instret", instret, 0);
        check("abort_imem_req", 32'(imem_req), 0);
        sb.delete();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        done = 1'b1;
      end else begin
        #1;
        imem_ack = imem_req && (iw == 0);
        if (imem_req && iw > 0) iw--;
        dmem_ack = dmem_req && (dw == 0);
        if (dmem_req && dw > 0) dw--;
        @(negedge clk);
        if (ir_we) {write_reg, write_mem, read_ram, illegal} = {wr, wm, rr, il};
        if (pc_we || state == 3'd5) done = 1'b1;
        tick();
        cyc++;
        if (cyc > 200) begin
          checks++;
          errors++;
          $display("FAIL instr_timeout: got %0d cycles expected under 200", cyc);
          done = 1'b1;
        end
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic trap_hold_and_reset();
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom);
      imem_ack = 1'($urandom);
      dmem_ack = 1'($urandom);
      @(negedge clk);
      check("trap_state", 32'(state), 5);
      check("trap_flag", 32'(trap), 1);
      check("trap_quiet", 32'({imem_req, ir_we, dmem_req, dmem_we,
                               mdr_we, rf_we, pc_we}), 0);
      tick();
    end
    run = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    check("trap_rst_state", 32'(state), 0);
    check("trap_rst_flag", 32'(trap), 0);
    check("trap_rst_instret", instret, 0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_trap", 32'(trap), 0);
    check("rst_instret", instret, 0);
    check("rst_outputs", 32'({imem_req, ir_we, dmem_req, dmem_we,
                              mdr_we, rf_we, pc_we}), 0);
    rst_n = 1'b1;

    run = 1'b0;
    imem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ir_we", 32'(ir_we), 0);
      check("idle_state", 32'(state), 0);
      check("idle_imem_req", 32'(imem_req), 0);
      tick();
    end
    imem_ack = 1'b0;
    run = 1'b1;
    sb.push_back('{3, 1'b0, 0, 1'b0});
    @(negedge clk);
    check("run_imem_req", 32'(imem_req), 1);
    tick();
    run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("held_imem_req", 32'(imem_req), 1);
      check("held_no_ir_we", 32'(ir_we), 0);
      tick();
    end
    imem_ack = 1'b1;
    @(negedge clk);
    check("held_ack_ir_we", 32'(ir_we), 1);
    tick();
    imem_ack = 1'b0;
    repeat (3) tick();

    exec_instr(1, 0, 0, 0, 0);
    exec_instr(2, 0, 3, 0, 0);
    exec_instr(3, 0, 2, 0, 0);
    for (int i = 0; i < 40; i++) begin
      exec_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 0);
    end

    @(negedge clk);
    #1;
    force dut.instret_q = 32'hFFFF_FFFF;
    exp_instret = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    release dut.instret_q;
    tick();
    exec_instr(1, 0, 0, 0, 0);
    exec_instr(0, 1, 0, 1, 0);

    exec_instr(2, 0, 10, 0, 5);
    exec_instr(0, 0, 0, 0, 0);

    exec_instr(4, 1, 0, 0, 0);
    trap_hold_and_reset();
    exec_instr(5, 0, 0, 0, 0);
    trap_hold_and_reset();
    exec_instr(2, 2, 1, 1, 0);

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 run  in  1  1 = permit next instruction fetch; sampled only in FETCH.
REQ-004 imem_ack  in  1  instruction memory has returned the instruction; valid only while imem_req=1.
REQ-005 dmem_ack  in  1  data memory access complete; valid only while dmem_req=1.
REQ-006 write_reg  in  1  decoder: instruction writes the register file.
REQ-007 write_mem  in  1  decoder: instruction stores to data memory.
REQ-008 read_ram  in  1  decoder: instruction loads from data memory.
REQ-009 illegal  in  1  decoder: alu_ctrl is the invalid code.
REQ-010 imem_req  out  1  instruction fetch request.
REQ-011 ir_we  out  1  one-cycle pulse: latch instruction register.
REQ-012 dmem_req  out  1  data memory request.
REQ-013 dmem_we  out  1  data request is a store.
REQ-014 mdr_we  out  1  one-cycle pulse: latch load data.
REQ-015 rf_we  out  1  register file write enable.
REQ-016 pc_we  out  1  one-cycle pulse: update PC (retire).
REQ-017 trap  out  1  sticky illegal-instruction flag.
REQ-018 state  out  3  current state encoding.
REQ-019 instret  out  32  retired-instruction counter.

Function
REQ-020 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 unreachable and SHALL go to FETCH.
REQ-021 Decoder inputs SHALL be sampled only in DECODE/EXEC/MEM/WB and are stable from the latched IR; values in FETCH are ignored.
REQ-022 FETCH: imem_req=run (combinational); on imem_ack=1 with imem_req=1 -> ir_we=1 same cycle, next DECODE; otherwise stay.
REQ-023 imem_req, once asserted, SHALL remain 1 until imem_ack, even if run falls.
REQ-024 DECODE: one cycle; illegal=1, or write_mem=read_ram=1 -> TRAP; else -> EXEC.
REQ-025 EXEC: one cycle; write_mem|read_ram -> MEM; else write_reg -> WB; else pc_we=1, -> FETCH (branch/jump/nop retire).
REQ-026 MEM: dmem_req=1, dmem_we=write_mem; held until dmem_ack; on ack: read_ram -> mdr_we=1, next WB; store -> pc_we=1, next FETCH.
REQ-027 WB: rf_we=1 and pc_we=1 for exactly one cycle, -> FETCH.
REQ-028 TRAP: trap=1; all request/enable outputs 0; remain until reset.
REQ-029 instret SHALL increment by 1 in the cycle after each pc_we pulse; wraps 0xFFFFFFFF -> 0.
REQ-030 Acks arriving while the matching req=0 SHALL be ignored.
REQ-031 Latency with zero-wait acks: branch/jump 3 cycles, ALU/store 4, load 5 (FETCH entry to next FETCH).
REQ-032 Outputs other than state and instret SHALL be combinational from state and inputs; no output is asserted outside its stated state.

Reset
REQ-033 rst_n=0 SHALL immediately force state=FETCH, trap=0, instret=0, and all request/enable outputs 0, including mid-MEM and in TRAP; pending requests are abandoned.
REQ-034 After rst_n rises, the first imem_req SHALL occur in the first cycle with run=1.

Verification
REQ-035 addu (write_reg=1), run=1, imem_ack in FETCH cycle -> states 0,1,2,4,0; rf_we and pc_we in cycle 4; instret 0->1.
REQ-036 lw (read_ram=1, write_reg=1), dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, mdr_we on ack cycle, then WB; 8 cycles total.
REQ-037 sw (write_mem=1) -> MEM with dmem_we=1, pc_we on ack cycle, rf_we never asserted.
REQ-038 illegal=1 in DECODE -> state=5, trap=1 held 20 cycles; rst_n pulse -> state=0, trap=0.
REQ-039 run=0 at FETCH, imem_ack pulsed -> no ir_we, state stays 0; run=1 -> imem_req; run dropped before ack -> imem_req stays 1 until ack.
REQ-040 instret preloaded to 0xFFFFFFFF via forced retire sequence -> next retire gives 0x00000000; rst_n low mid-MEM -> dmem_req=0 in the same cycle.
